// File: rtl/bus_sequencer_if.sv
// Core-request and memory-bus signals of the bus sequencer, bundled for port use.
// The master modport is the core plus memory side; the slave modport is the sequencer.
interface bus_sequencer_if #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int MAX_BEATS = 2
);
  localparam int LW = $clog2(MAX_BEATS);

  // Core request channel
  logic                    req;
  logic                    we;
  logic [AW-1:0]           addr;
  logic [LW-1:0]           len;
  logic [MAX_BEATS*DW-1:0] wdata;
  logic [MAX_BEATS*DW-1:0] rdata;
  logic                    ack;
  logic                    busy;

  // External memory bus
  logic [AW-1:0]           address;
  logic [DW-1:0]           data_out;
  logic                    data_oe;
  logic                    read_en;
  logic [DW-1:0]           data_in;
  logic                    mem_ready;

  modport master (
    output req, we, addr, len, wdata, data_in, mem_ready,
    input  rdata, ack, busy, address, data_out, data_oe, read_en
  );

  modport slave (
    input  req, we, addr, len, wdata, data_in, mem_ready,
    output rdata, ack, busy, address, data_out, data_oe, read_en
  );
endinterface

// File: rtl/bus_sequencer.sv
// Memory-bus sequencer: runs one latched request of 1..MAX_BEATS byte beats with
// fixed plus ready-driven wait states, optional 6502 page-wrap, little-endian read assembly.
module bus_sequencer #(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int MAX_BEATS   = 2,
  parameter int WAIT_CYCLES = 0,
  parameter int PAGE_WRAP   = 0
) (
  input  logic             ph1,
  input  logic             reset,
  bus_sequencer_if.slave   bus
);

  localparam int LW  = $clog2(MAX_BEATS);
  localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic                    we_q;
  logic [LW-1:0]           len_q;
  logic [MAX_BEATS*DW-1:0] wdata_q;
  logic [MAX_BEATS*DW-1:0] rdata_q;
  logic [LW-1:0]           beat;
  logic [LW-1:0]           beat_inc;
  logic [WCW-1:0]          wait_cnt;
  logic [AW-1:0]           address_q;
  logic [AW-1:0]           addr_inc;
  logic [AW-1:0]           address_nxt;
  logic [DW-1:0]           data_out_q;

  logic                    accept;
  logic                    beat_done;
  logic                    last_beat;
  logic                    ack;
  logic                    busy;
  logic                    read_en;

  assign last_beat = (beat == len_q);
  assign beat_inc  = beat + 1'b1;
  assign addr_inc  = address_q + AW'(1);

  // Page-wrap keeps the high byte so a vector fetch at xxFF reads xx00 next, as on the 6502.
  assign address_nxt = (PAGE_WRAP != 0) ? {address_q[AW-1:8], addr_inc[7:0]} : addr_inc;

  // NOTE: state and datapath registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    beat_done = 1'b0;
    ack       = 1'b0;
    busy      = 1'b1;
    read_en   = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.req) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        read_en = ~we_q;
        // mem_ready only matters once the fixed wait count has run out
        if ((wait_cnt == '0) && bus.mem_ready) begin
          beat_done = 1'b1;
          if (last_beat) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: rdata is a register bank that is cleared on reset on purpose, so a request
  // aborted by reset never leaves partial read bytes visible to the core.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      we_q       <= 1'b0;
      len_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      beat       <= '0;
      wait_cnt   <= WAIT_LOAD;
      address_q  <= '0;
      data_out_q <= '0;
    end else if (accept) begin
      we_q      <= bus.we;
      len_q     <= bus.len;
      wdata_q   <= bus.wdata;
      address_q <= bus.addr;
      beat      <= '0;
      wait_cnt  <= WAIT_LOAD;
      if (bus.we) begin
        data_out_q <= bus.wdata[DW-1:0];
      end
    end else if (state == ACCESS) begin
      if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end else if (beat_done) begin
        if (!we_q) begin
          rdata_q[beat*DW +: DW] <= bus.data_in;
        end
        if (!last_beat) begin
          beat      <= beat_inc;
          address_q <= address_nxt;
          wait_cnt  <= WAIT_LOAD;
          // Present the next write byte together with the next address.
          if (we_q) begin
            data_out_q <= wdata_q[beat_inc*DW +: DW];
          end
        end
      end
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ack      = ack;
  assign bus.busy     = busy;
  assign bus.address  = address_q;
  assign bus.data_out = data_out_q;
  assign bus.read_en  = read_en;
  assign bus.data_oe  = ~read_en;

endmodule
